seq_phase_sequencer: RTL and testbench

- Hardware cycle controller for the Y86-64 sequential core.
- Generates the per-instruction phase strobes consumed by the stage modules:
  - flag_1: fetch/decode.
  - flag_2: execute/memory.
  - flag_3: write-back.
  - pc_clk: PC update.
- Owns the architectural PC register: loads updated_pc at the end of every instruction.
- Terminates on halt or on an instruction/data memory error, and reports Y86 status.

---
 rtl/seq_phase_sequencer.sv | 149 ++++++++++++++
 tb/tb_seq_phase_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_phase_sequencer.sv
// Phase-strobe cycle controller and architectural PC owner for the Y86-64 sequential core.
// Optional single-step pause after each instruction: define SEQ_PHASE_SEQUENCER_STEP_EN.
module seq_phase_sequencer #(
  parameter logic [63:0] RESET_PC    = 64'd1,
  parameter int unsigned PHASE_TICKS = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic [63:0]      updated_pc,
  output logic             flag_1,
  output logic             flag_2,
  output logic             flag_3,
  output logic             pc_clk,
  output logic [63:0]      pc,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] instr_count
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
  ,
  input  logic             step
`endif
);

  localparam int TICK_W = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(PHASE_TICKS - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_HI,
    S_F_LO,
    S_E_HI,
    S_P_LO,
    S_E_LO,
    S_W_HI,
    S_W_LO,
    S_P_HI,
    S_LATCH,
    S_DONE
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
    ,
    S_PAUSE
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [2:0]         stat_q, stat_d;
  logic               last_tick;
  logic               flag_1_q, flag_2_q, flag_3_q, pc_clk_q, running_q;
  logic [63:0]        pc_q;
  logic [CNT_W-1:0]   instr_count_q;

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    last_tick = (tick_q == LAST_TICK);
    case (state_q)
      S_IDLE: if (start) state_d = S_F_HI;
      S_F_HI: if (last_tick) state_d = S_F_LO;
      S_F_LO: begin
        if (last_tick) begin
          if (imem_error) begin
            state_d = S_DONE;
            stat_d  = STAT_ADR;
          end else if (halt) begin
            state_d = S_DONE;
            stat_d  = STAT_HLT;
          end else begin
            state_d = S_E_HI;
          end
        end
      end
      S_E_HI: if (last_tick) state_d = S_P_LO;
      S_P_LO: if (last_tick) state_d = S_E_LO;
      S_E_LO: begin
        if (last_tick) begin
          if (dmem_error) begin
            state_d = S_DONE;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_W_HI;
          end
        end
      end
      S_W_HI: if (last_tick) state_d = S_W_LO;
      S_W_LO: if (last_tick) state_d = S_P_HI;
      S_P_HI: if (last_tick) state_d = S_LATCH;
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
      S_LATCH: state_d = S_PAUSE;
      S_PAUSE: if (step) state_d = S_F_HI;
`else
      S_LATCH: state_d = S_F_HI;
`endif
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    // Restart the tick count on every state change; LATCH always leaves after one cycle.
    tick_d = (state_d == state_q && !last_tick) ? tick_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tick_q        <= '0;
      stat_q        <= STAT_AOK;
      flag_1_q      <= 1'b0;
      flag_2_q      <= 1'b0;
      flag_3_q      <= 1'b0;
      pc_clk_q      <= 1'b1;
      running_q     <= 1'b0;
      pc_q          <= RESET_PC;
      instr_count_q <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      stat_q    <= stat_d;
      // Strobes are decoded from the next state so they align with the state register.
      flag_1_q  <= (state_d == S_F_HI);
      flag_2_q  <= (state_d == S_E_HI) || (state_d == S_P_LO);
      flag_3_q  <= (state_d == S_W_HI);
      pc_clk_q  <= !((state_d == S_P_LO) || (state_d == S_E_LO) ||
                     (state_d == S_W_HI) || (state_d == S_W_LO));
      running_q <= (state_d != S_IDLE) && (state_d != S_DONE);
      if (state_q == S_LATCH) begin
        pc_q          <= updated_pc;
        instr_count_q <= instr_count_q + 1'b1;
      end
    end
  end

  assign flag_1      = flag_1_q;
  assign flag_2      = flag_2_q;
  assign flag_3      = flag_3_q;
  assign pc_clk      = pc_clk_q;
  assign running     = running_q;
  assign pc          = pc_q;
  assign stat        = stat_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_seq_phase_sequencer.sv
// Bench for seq_phase_sequencer: two instances (PHASE_TICKS 1 and 3) checked every cycle against
// a position-within-instruction model, plus directed literal checks.
module tb_seq_phase_sequencer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
  localparam bit HAS_STEP = 1'b1;
`else
  localparam bit HAS_STEP = 1'b0;
`endif
  // Cycles per instruction for the PHASE_TICKS=1 instance (step held high adds one PAUSE cycle).
  localparam int I1 = HAS_STEP ? 10 : 9;

  logic clk;
  logic rst_n;
  logic chk_en;
  logic start_a [2];
  logic halt_a  [2];
  logic imem_a  [2];
  logic dmem_a  [2];
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
  logic step_a  [2];
`endif
  int checks;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic lit(input string name, input int inst, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int PT = (gi == 0) ? 1 : 3;
    logic        f1, f2, f3, pclk, run;
    logic [63:0] pc, upd;
    logic [2:0]  st;
    logic [31:0] cnt;

    assign upd = pc + 64'd2;

    seq_phase_sequencer #(.RESET_PC(64'd1), .PHASE_TICKS(PT), .CNT_W(32)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_a[gi]),
      .halt        (halt_a[gi]),
      .imem_error  (imem_a[gi]),
      .dmem_error  (dmem_a[gi]),
      .updated_pc  (upd),
      .flag_1      (f1),
      .flag_2      (f2),
      .flag_3      (f3),
      .pc_clk      (pclk),
      .pc          (pc),
      .stat        (st),
      .running     (run),
      .instr_count (cnt)
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
      ,
      .step        (step_a[gi])
`endif
    );

    // Model: mode plus cycle position inside the instruction (0 .. 8*PT, the last being LATCH).
    int          m_mode;
    int          m_pos;
    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    logic [31:0] m_cnt;
    int          e_ph;
    logic        e_act;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_mode <= M_IDLE;
        m_pos  <= 0;
        m_pc   <= 64'd1;
        m_stat <= 3'd1;
        m_cnt  <= 32'd0;
      end else begin
        case (m_mode)
          M_IDLE: if (start_a[gi]) begin
            m_mode <= M_RUN;
            m_pos  <= 0;
          end
          M_RUN: begin
            if (m_pos == 2 * PT - 1 && (imem_a[gi] || halt_a[gi])) begin
              m_mode <= M_DONE;
              m_stat <= imem_a[gi] ? 3'd3 : 3'd2;
            end else if (m_pos == 5 * PT - 1 && dmem_a[gi]) begin
              m_mode <= M_DONE;
              m_stat <= 3'd3;
            end else if (m_pos == 8 * PT) begin
              m_pc  <= m_pc + 64'd2;
              m_cnt <= m_cnt + 32'd1;
              m_pos <= 0;
              if (HAS_STEP) m_mode <= M_PAUSE;
            end else begin
              m_pos <= m_pos + 1;
            end
          end
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
          M_PAUSE: if (step_a[gi]) begin
            m_mode <= M_RUN;
            m_pos  <= 0;
          end
`endif
          default: ;
        endcase
      end
    end

    assign e_ph  = m_pos / PT;
    assign e_act = (m_mode == M_RUN);

    always @(negedge clk) begin
      if (chk_en) begin
        lit("flag_1", gi, 64'(f1), 64'(e_act && e_ph == 0));
        lit("flag_2", gi, 64'(f2), 64'(e_act && (e_ph == 2 || e_ph == 3)));
        lit("flag_3", gi, 64'(f3), 64'(e_act && e_ph == 5));
        lit("pc_clk", gi, 64'(pclk), 64'(!(e_act && e_ph >= 3 && e_ph <= 6)));
        lit("running", gi, 64'(run), 64'(m_mode == M_RUN || m_mode == M_PAUSE));
        lit("pc", gi, pc, m_pc);
        lit("stat", gi, 64'(st), 64'(m_stat));
        lit("instr_count", gi, 64'(cnt), 64'(m_cnt));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic pulse_start(input int i);
    start_a[i] = 1'b1;
    cyc(1);
    start_a[i] = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0;
      halt_a[i]  = 1'b0;
      imem_a[i]  = 1'b0;
      dmem_a[i]  = 1'b0;
    end
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
    step_a[0] = 1'b1;
    step_a[1] = 1'b0;
`endif
    cyc(3);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    cyc(1);
    $display("reset: pc=%0h stat=%0d running=%0d", g_inst[0].pc, g_inst[0].st, g_inst[0].run);
    lit("rst_pc", 0, g_inst[0].pc, 64'd1);
    lit("rst_stat", 0, 64'(g_inst[0].st), 64'd1);
    lit("rst_running", 0, 64'(g_inst[0].run), 64'd0);
    lit("rst_count", 0, 64'(g_inst[0].cnt), 64'd0);
    lit("rst_pc_clk", 0, 64'(g_inst[0].pclk), 64'd1);

    // Free run: pc 1, 3, 5, 7 at I1-cycle spacing.
    pulse_start(0);
    $display("start: flag_1=%0d", g_inst[0].f1);
    lit("first_flag_1", 0, 64'(g_inst[0].f1), 64'd1);
    lit("run_running", 0, 64'(g_inst[0].run), 64'd1);
    cyc(1);
    lit("f_lo_flag_1", 0, 64'(g_inst[0].f1), 64'd0);
    cyc(5);
    lit("w_lo_pc_clk", 0, 64'(g_inst[0].pclk), 64'd0);
    cyc(1);
    lit("p_hi_pc_clk", 0, 64'(g_inst[0].pclk), 64'd1);
    cyc(I1 - 7);
    $display("instr 2: pc=%0h", g_inst[0].pc);
    lit("pc_instr2", 0, g_inst[0].pc, 64'd3);
    lit("flag_1_instr2", 0, 64'(g_inst[0].f1), 64'd1);
    cyc(I1);
    $display("instr 3: pc=%0h", g_inst[0].pc);
    lit("pc_instr3", 0, g_inst[0].pc, 64'd5);
    cyc(I1);
    $display("instr 4: pc=%0h count=%0d", g_inst[0].pc, g_inst[0].cnt);
    lit("count_3", 0, 64'(g_inst[0].cnt), 64'd3);
    lit("pc_instr4", 0, g_inst[0].pc, 64'd7);

    // Halt during the 4th fetch.
    halt_a[0] = 1'b1;
    cyc(2);
    halt_a[0] = 1'b0;
    $display("halt: stat=%0d pc=%0h count=%0d", g_inst[0].st, g_inst[0].pc, g_inst[0].cnt);
    lit("halt_stat", 0, 64'(g_inst[0].st), 64'd2);
    lit("halt_running", 0, 64'(g_inst[0].run), 64'd0);
    lit("halt_pc", 0, g_inst[0].pc, 64'd7);
    lit("halt_count", 0, 64'(g_inst[0].cnt), 64'd3);
    pulse_start(0);
    cyc(8);
    lit("halt_no_flag_2", 0, 64'(g_inst[0].f2), 64'd0);
    lit("done_ignores_start", 0, 64'(g_inst[0].run), 64'd0);

    // imem_error and halt together in F_LO.
    do_reset();
    pulse_start(0);
    cyc(1);
    imem_a[0] = 1'b1;
    halt_a[0] = 1'b1;
    cyc(1);
    imem_a[0] = 1'b0;
    halt_a[0] = 1'b0;
    $display("imem+halt: stat=%0d", g_inst[0].st);
    lit("imem_stat", 0, 64'(g_inst[0].st), 64'd3);
    lit("imem_pc", 0, g_inst[0].pc, 64'd1);
    cyc(3);

    // dmem_error in E_LO of the 2nd instruction.
    do_reset();
    pulse_start(0);
    cyc(I1 + 4);
    lit("e_lo_pc_clk", 0, 64'(g_inst[0].pclk), 64'd0);
    dmem_a[0] = 1'b1;
    cyc(1);
    dmem_a[0] = 1'b0;
    $display("dmem: stat=%0d pc=%0h count=%0d", g_inst[0].st, g_inst[0].pc, g_inst[0].cnt);
    lit("dmem_stat", 0, 64'(g_inst[0].st), 64'd3);
    lit("dmem_pc", 0, g_inst[0].pc, 64'd3);
    lit("dmem_count", 0, 64'(g_inst[0].cnt), 64'd1);
    cyc(5);
    lit("dmem_no_flag_3", 0, 64'(g_inst[0].f3), 64'd0);

    // Asynchronous reset while in W_HI.
    do_reset();
    pulse_start(0);
    cyc(5);
    lit("w_hi_flag_3", 0, 64'(g_inst[0].f3), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    $display("async reset: flag_3=%0d pc_clk=%0d pc=%0h", g_inst[0].f3, g_inst[0].pclk, g_inst[0].pc);
    lit("arst_flag_3", 0, 64'(g_inst[0].f3), 64'd0);
    lit("arst_pc_clk", 0, 64'(g_inst[0].pclk), 64'd1);
    lit("arst_pc", 0, g_inst[0].pc, 64'd1);
    lit("arst_stat", 0, 64'(g_inst[0].st), 64'd1);
    lit("arst_count", 0, 64'(g_inst[0].cnt), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    pulse_start(0);
    lit("resume_flag_1", 0, 64'(g_inst[0].f1), 64'd1);
    cyc(I1);
    $display("resume: pc=%0h", g_inst[0].pc);
    lit("resume_pc", 0, g_inst[0].pc, 64'd3);

    // PHASE_TICKS=3 instance: 3-cycle strobes, 25-cycle instruction.
    pulse_start(1);
    lit("pt3_flag_1_a", 1, 64'(g_inst[1].f1), 64'd1);
    cyc(2);
    lit("pt3_flag_1_c", 1, 64'(g_inst[1].f1), 64'd1);
    cyc(1);
    lit("pt3_flag_1_end", 1, 64'(g_inst[1].f1), 64'd0);
    cyc(3);
    lit("pt3_flag_2", 1, 64'(g_inst[1].f2), 64'd1);
    cyc(18);
    lit("pt3_latch_pc", 1, g_inst[1].pc, 64'd1);
    cyc(1);
    $display("pt3 instr 2: pc=%0h count=%0d", g_inst[1].pc, g_inst[1].cnt);
    lit("pt3_pc", 1, g_inst[1].pc, 64'd3);
    lit("pt3_count", 1, 64'(g_inst[1].cnt), 64'd1);
`ifdef SEQ_PHASE_SEQUENCER_STEP_EN
    lit("pause_flag_1", 1, 64'(g_inst[1].f1), 64'd0);
    lit("pause_running", 1, 64'(g_inst[1].run), 64'd1);
    cyc(3);
    lit("pause_hold", 1, 64'(g_inst[1].f1), 64'd0);
    step_a[1] = 1'b1;
    cyc(1);
    step_a[1] = 1'b0;
    $display("step: flag_1=%0d", g_inst[1].f1);
    lit("step_flag_1", 1, 64'(g_inst[1].f1), 64'd1);
`else
    lit("pt3_flag_1_instr2", 1, 64'(g_inst[1].f1), 64'd1);
`endif
    cyc(60);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
